// File: rtl/dac_arbiter_pkg.sv
// rtl/dac_arbiter_pkg.sv - shared types and constants for the DAC arbiter
package dac_arbiter_pkg;

  localparam int ARB_IDX_WID = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_GAP     = 2'd3
  } arb_state_e;

endpackage

// File: rtl/dac_arbiter_rr_select.sv
// rtl/dac_arbiter_rr_select.sv - round-robin picker: first eligible index after ptr, wrapping
module dac_arbiter_rr_select
  import dac_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]             eligible_i,
  input  logic [ARB_IDX_WID-1:0]   ptr_i,
  output logic                     found_o,
  output logic [ARB_IDX_WID-1:0]   idx_o
);

  // Second pass (indices above ptr) overrides the wrapped pass; descending scans leave the lowest hit.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible_i[i] && (ARB_IDX_WID'(i) <= ptr_i)) begin
        found_o = 1'b1;
        idx_o   = ARB_IDX_WID'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible_i[i] && (ARB_IDX_WID'(i) > ptr_i)) begin
        found_o = 1'b1;
        idx_o   = ARB_IDX_WID'(i);
      end
    end
  end

endmodule

// File: rtl/dac_arbiter.sv
// rtl/dac_arbiter.sv - round-robin sharing of one DAC SPI master among several requesters
module dac_arbiter
  import dac_arbiter_pkg::*;
#(
  parameter int MASTER_NUM       = 3,
  parameter int DAC_WID          = 24,
  parameter int WAIT_BETWEEN_CMD = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MASTER_NUM-1:0]         req_arm,
  input  logic [MASTER_NUM*DAC_WID-1:0] req_to_dac,
  output logic [MASTER_NUM*DAC_WID-1:0] req_from_dac,
  output logic [MASTER_NUM-1:0]         req_finished,
  output logic                          dac_arm,
  output logic [DAC_WID-1:0]            dac_to_dac,
  input  logic [DAC_WID-1:0]            dac_from_dac,
  input  logic                          dac_finished,
  output logic                          busy,
  output logic [ARB_IDX_WID-1:0]        grant_idx
);

  localparam int GAP_W = (WAIT_BETWEEN_CMD > 1) ? $clog2(WAIT_BETWEEN_CMD) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((WAIT_BETWEEN_CMD > 0) ? (WAIT_BETWEEN_CMD - 1) : 0);
  localparam logic [ARB_IDX_WID-1:0] PTR_RST = ARB_IDX_WID'(MASTER_NUM - 1);

  arb_state_e                    state_q, state_d;
  logic [ARB_IDX_WID-1:0]        ptr_q, ptr_d;
  logic [ARB_IDX_WID-1:0]        grant_q, grant_d;
  logic [DAC_WID-1:0]            to_dac_q, to_dac_d;
  logic                          arm_q, arm_d;
  logic [MASTER_NUM-1:0]         fin_q, fin_d;
  logic [MASTER_NUM*DAC_WID-1:0] from_q, from_d;
  logic [GAP_W-1:0]              gap_q, gap_d;

  logic [MASTER_NUM-1:0]  eligible;
  logic                   sel_found;
  logic [ARB_IDX_WID-1:0] sel_idx;
  logic [DAC_WID-1:0]     sel_word;
  logic                   grant_arm;

  assign eligible = req_arm & ~fin_q;

  dac_arbiter_rr_select #(
    .N(MASTER_NUM)
  ) u_rr_select (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .found_o    (sel_found),
    .idx_o      (sel_idx)
  );

  always_comb begin
    sel_word  = '0;
    grant_arm = 1'b0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (sel_idx == ARB_IDX_WID'(i)) sel_word = req_to_dac[i*DAC_WID +: DAC_WID];
      if (grant_q == ARB_IDX_WID'(i)) grant_arm = req_arm[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    to_dac_d = to_dac_q;
    arm_d    = arm_q;
    fin_d    = fin_q;
    from_d   = from_q;
    gap_d    = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          grant_d  = sel_idx;
          to_dac_d = sel_word;
          arm_d    = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (dac_finished) begin
          for (int i = 0; i < MASTER_NUM; i++) begin
            if (grant_q == ARB_IDX_WID'(i)) begin
              from_d[i*DAC_WID +: DAC_WID] = dac_from_dac;
              fin_d[i]                     = 1'b1;
            end
          end
          arm_d   = 1'b0;
          ptr_d   = grant_q;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Only the grantee's flag can be set here, so clearing all of them is exact.
        if (!grant_arm && !dac_finished) begin
          fin_d = '0;
          if (WAIT_BETWEEN_CMD > 0) begin
            gap_d   = '0;
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= PTR_RST;
      grant_q  <= '0;
      to_dac_q <= '0;
      arm_q    <= 1'b0;
      fin_q    <= '0;
      from_q   <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      to_dac_q <= to_dac_d;
      arm_q    <= arm_d;
      fin_q    <= fin_d;
      from_q   <= from_d;
      gap_q    <= gap_d;
    end
  end

  assign req_from_dac = from_q;
  assign req_finished = fin_q;
  assign dac_arm      = arm_q;
  assign dac_to_dac   = to_dac_q;
  assign busy         = (state_q != ST_IDLE);
  assign grant_idx    = grant_q;

endmodule
